// File: rtl/dmem_dump_ctrl.sv
// Data-memory dump controller: on trap it drains the pipeline, takes the data
// memory away from the MEM stage and streams DUMP_BASE..DUMP_LIMIT-4 out over valid/ready.
module dmem_dump_ctrl #(
  parameter logic [31:0] DUMP_BASE    = 32'h2000,
  parameter logic [31:0] DUMP_LIMIT   = 32'h2100,
  parameter int unsigned DRAIN_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        trap,
  input  logic [31:0] pipe_addr,
  input  logic [31:0] pipe_wdata,
  input  logic        pipe_memwr,
  output logic [31:0] pipe_rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_wr,
  input  logic [31:0] mem_rdata,
  output logic        stall_fetch,
  output logic        dump_valid,
  output logic [31:0] dump_addr,
  output logic [31:0] dump_data,
  input  logic        dump_ready,
  output logic        done,
  output logic        wr_err
);

  // state    | meaning
  // RUN      | pipeline owns the data memory
  // DRAIN    | trap taken, in-flight stores still reach memory
  // DUMP_RD  | read the word at ptr into the dump registers
  // DUMP_OUT | word presented, waiting for dump_ready
  // DONE     | dump finished, held until reset
  typedef enum logic [2:0] {
    S_RUN      = 3'd0,
    S_DRAIN    = 3'd1,
    S_DUMP_RD  = 3'd2,
    S_DUMP_OUT = 3'd3,
    S_DONE     = 3'd4
  } state_t;

  localparam logic [31:0] DRAIN_LOAD = (DRAIN_CYCLES == 0) ? 32'd0 : 32'(DRAIN_CYCLES - 1);

  state_t      r_state;
  state_t      w_state_nxt;
  logic [31:0] r_ptr;
  logic [31:0] r_drain_cnt;
  logic        r_dump_valid;
  logic [31:0] r_dump_addr;
  logic [31:0] r_dump_data;
  logic        r_done;
  logic        r_stall;
  logic        r_wr_err;
  logic        w_owned;
  logic [31:0] w_ptr_inc;
  logic        w_last;

  assign w_owned   = (r_state == S_RUN) || (r_state == S_DRAIN);
  // 32-bit wrap is intended: a limit at or below the base still yields one word
  assign w_ptr_inc = r_ptr + 32'd4;
  assign w_last    = (w_ptr_inc >= DUMP_LIMIT);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= S_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_RUN:      if (trap) w_state_nxt = (DRAIN_CYCLES == 0) ? S_DUMP_RD : S_DRAIN;
      S_DRAIN:    if (r_drain_cnt == 32'd0) w_state_nxt = S_DUMP_RD;
      S_DUMP_RD:  w_state_nxt = S_DUMP_OUT;
      S_DUMP_OUT: if (dump_ready) w_state_nxt = w_last ? S_DONE : S_DUMP_RD;
      S_DONE:     w_state_nxt = S_DONE;
      default:    w_state_nxt = S_RUN;
    endcase
  end

  always_comb begin
    mem_addr    = w_owned ? pipe_addr  : r_ptr;
    mem_wdata   = w_owned ? pipe_wdata : 32'd0;
    mem_wr      = w_owned ? pipe_memwr : 1'b0;
    pipe_rdata  = w_owned ? mem_rdata  : 32'd0;
    stall_fetch = r_stall;
    dump_valid  = r_dump_valid;
    dump_addr   = r_dump_addr;
    dump_data   = r_dump_data;
    done        = r_done;
    wr_err      = r_wr_err;
  end

  // status flags are flopped from the next state so dump_valid never sees dump_ready combinationally
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr        <= DUMP_BASE;
      r_drain_cnt  <= 32'd0;
      r_dump_valid <= 1'b0;
      r_dump_addr  <= 32'd0;
      r_dump_data  <= 32'd0;
      r_done       <= 1'b0;
      r_stall      <= 1'b0;
      r_wr_err     <= 1'b0;
    end else begin
      r_stall      <= (w_state_nxt != S_RUN);
      r_done       <= (w_state_nxt == S_DONE);
      r_dump_valid <= (w_state_nxt == S_DUMP_OUT);

      if (r_state == S_RUN && trap)
        r_drain_cnt <= DRAIN_LOAD;
      else if (r_state == S_DRAIN && r_drain_cnt != 32'd0)
        r_drain_cnt <= r_drain_cnt - 32'd1;

      if (w_owned && w_state_nxt == S_DUMP_RD)
        r_ptr <= DUMP_BASE;
      else if (r_state == S_DUMP_OUT && dump_ready)
        r_ptr <= w_ptr_inc;

      if (r_state == S_DUMP_RD) begin
        r_dump_addr <= r_ptr;
        r_dump_data <= mem_rdata;
      end

      if (!w_owned && pipe_memwr)
        r_wr_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dmem_dump_ctrl.sv
// Bench for dmem_dump_ctrl: behavioural memory + dump model checked every cycle,
// with directed pass-through, full-dump, backpressure, illegal-store and reset-mid-dump scenarios.
module tb_dmem_dump_ctrl;
  localparam logic [31:0] BASE  = 32'h2000;
  localparam logic [31:0] LIMIT = 32'h2100;
  localparam int          DRAIN = 2;
  localparam int NWORDS = (LIMIT > BASE) ? int'((LIMIT - BASE + 32'd3) / 32'd4) : 1;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        trap = 1'b0;
  logic [31:0] pipe_addr = 32'd0;
  logic [31:0] pipe_wdata = 32'd0;
  logic        pipe_memwr = 1'b0;
  logic        dump_ready = 1'b0;
  logic [31:0] pipe_rdata, mem_addr, mem_wdata, mem_rdata, dump_addr, dump_data;
  logic        mem_wr, stall_fetch, dump_valid, done, wr_err;

  always #5 clk = ~clk;

  dmem_dump_ctrl #(.DUMP_BASE(BASE), .DUMP_LIMIT(LIMIT), .DRAIN_CYCLES(DRAIN)) dut (
    .clk(clk), .reset(reset), .trap(trap),
    .pipe_addr(pipe_addr), .pipe_wdata(pipe_wdata), .pipe_memwr(pipe_memwr),
    .pipe_rdata(pipe_rdata), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wr(mem_wr), .mem_rdata(mem_rdata), .stall_fetch(stall_fetch),
    .dump_valid(dump_valid), .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_ready(dump_ready), .done(done), .wr_err(wr_err)
  );

  // data memory seen by the DUT, and the bench's own expectation of its contents
  logic [31:0] env_mem [0:255];
  logic [31:0] ref_mem [0:255];
  logic        preload = 1'b1;

  assign mem_rdata = env_mem[mem_addr[9:2]];

  always @(posedge clk) begin
    if (preload) for (int i = 0; i < 256; i++) env_mem[i] <= BASE + 32'(4 * i);
    else if (mem_wr) env_mem[mem_addr[9:2]] <= mem_wdata;
  end

  // reference model: trap -> DRAIN ownership cycles -> NWORDS words, each one read cycle plus accept
  bit m_trapped, m_reading, m_finished, m_wr_err;
  int m_drain_left, m_word;

  always @(posedge clk or negedge reset) begin
    if (preload) for (int i = 0; i < 256; i++) ref_mem[i] = BASE + 32'(4 * i);
    if (!reset) begin
      m_trapped = 0; m_reading = 0; m_finished = 0; m_wr_err = 0;
      m_drain_left = 0; m_word = 0;
    end else if (!m_trapped || m_drain_left > 0) begin
      if (pipe_memwr) ref_mem[pipe_addr[9:2]] = pipe_wdata;
      if (!m_trapped) begin
        if (trap) begin
          m_trapped = 1; m_word = 0; m_drain_left = DRAIN; m_reading = (DRAIN == 0);
        end
      end else begin
        m_drain_left--;
        if (m_drain_left == 0) m_reading = 1;
      end
    end else begin
      if (pipe_memwr) m_wr_err = 1;
      if (!m_finished) begin
        if (m_reading) m_reading = 0;
        else if (dump_ready) begin
          m_word++;
          if (m_word == NWORDS) m_finished = 1;
          else m_reading = 1;
        end
      end
    end
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
    end
  endtask

  bit          c_owned, c_valid;
  logic [31:0] c_ptr;

  initial begin
    forever begin
      @(negedge clk); #2;
      c_owned = !m_trapped || m_drain_left > 0;
      c_valid = m_trapped && m_drain_left == 0 && !m_reading && !m_finished;
      c_ptr   = BASE + 32'(4 * m_word);
      chk("stall_fetch", 32'(stall_fetch), 32'(m_trapped));
      chk("done", 32'(done), 32'(m_finished));
      chk("dump_valid", 32'(dump_valid), 32'(c_valid));
      chk("wr_err", 32'(wr_err), 32'(m_wr_err));
      chk("mem_wr", 32'(mem_wr), c_owned ? 32'(pipe_memwr) : 32'd0);
      chk("mem_addr", mem_addr, c_owned ? pipe_addr : c_ptr);
      chk("mem_wdata", mem_wdata, c_owned ? pipe_wdata : 32'd0);
      chk("pipe_rdata", pipe_rdata, c_owned ? ref_mem[pipe_addr[9:2]] : 32'd0);
      if (c_valid) begin
        chk("dump_addr", dump_addr, c_ptr);
        chk("dump_data", dump_data, ref_mem[c_ptr[9:2]]);
      end
    end
  end

  logic [31:0] log_addr [$];
  logic [31:0] log_data [$];

  always @(posedge clk)
    if (reset && dump_valid && dump_ready) begin
      log_addr.push_back(dump_addr);
      log_data.push_back(dump_data);
    end

  task automatic idle_inputs();
    trap = 0; pipe_memwr = 0; pipe_addr = 0; pipe_wdata = 0; dump_ready = 0;
  endtask

  function automatic logic [31:0] rnd_addr();
    return BASE + 32'($urandom_range(0, 63)) * 32'd4;
  endfunction

  initial begin
    int n, cnt_2010, errs;
    bit bp_done;
    logic [31:0] d2004;

    idle_inputs();
    @(posedge clk); #1 preload = 0;
    @(negedge clk); #1;
    chk("rst_stall", 32'(stall_fetch), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(dump_valid), 32'd0);
    chk("rst_dump_addr", dump_addr, 32'd0);
    chk("rst_dump_data", dump_data, 32'd0);
    chk("rst_wr_err", 32'(wr_err), 32'd0);
    @(negedge clk) reset = 1;

    // store pass-through in RUN
    @(negedge clk);
    pipe_addr = 32'h2000; pipe_wdata = 32'hDEADBEEF; pipe_memwr = 1;
    #1;
    chk("pass_mem_wr", 32'(mem_wr), 32'd1);
    chk("pass_mem_addr", mem_addr, 32'h2000);
    chk("pass_mem_wdata", mem_wdata, 32'hDEADBEEF);
    chk("pass_stall", 32'(stall_fetch), 32'd0);
    @(negedge clk) pipe_wdata = 32'h2000;
    @(negedge clk) pipe_memwr = 0;

    // full dump, dump_ready tied high
    log_addr.delete(); log_data.delete();
    trap = 1; dump_ready = 1;
    @(posedge clk); #1 trap = 0;
    n = 0;
    while (!done && n < 400) begin @(posedge clk); n++; #1; end
    chk("done_latency", 32'(n), 32'd130);
    chk("full_count", 32'(log_addr.size()), 32'd64);
    errs = 0;
    for (int k = 0; k < log_addr.size(); k++)
      if (log_addr[k] !== 32'h2000 + 32'(4 * k) || log_data[k] !== 32'h2000 + 32'(4 * k)) errs++;
    chk("full_addr_data", 32'(errs), 32'd0);
    chk("full_wr_err", 32'(wr_err), 32'd0);

    // random stores, drain store, backpressure and illegal store
    @(negedge clk) begin reset = 0; idle_inputs(); end
    @(negedge clk) reset = 1;
    repeat (20) begin
      @(negedge clk);
      pipe_memwr = ($urandom_range(0, 2) == 0); pipe_addr = rnd_addr(); pipe_wdata = $urandom;
    end
    @(negedge clk) begin pipe_memwr = 0; trap = 1; end
    @(negedge clk) begin trap = 0; pipe_addr = 32'h2004; pipe_wdata = 32'h12345678; pipe_memwr = 1; end
    @(negedge clk) pipe_memwr = 0;
    log_addr.delete(); log_data.delete();
    n = 0; bp_done = 0;
    while (!done && n < 3000) begin
      if (dump_valid && dump_addr == 32'h2010 && !bp_done) begin
        dump_ready = 0; pipe_memwr = 1; pipe_addr = 32'h2010; pipe_wdata = 32'hCAFEF00D;
        #1 chk("illegal_mem_wr", 32'(mem_wr), 32'd0);
        repeat (10) @(negedge clk);
        pipe_memwr = 0; dump_ready = 1; bp_done = 1;
      end else begin
        dump_ready = ($urandom_range(0, 3) != 0);
        pipe_memwr = ($urandom_range(0, 7) == 0);
        pipe_addr = rnd_addr(); pipe_wdata = $urandom;
      end
      @(negedge clk); n++;
    end
    idle_inputs();
    chk("rand_done", 32'(done), 32'd1);
    chk("rand_count", 32'(log_addr.size()), 32'(NWORDS));
    errs = 0; cnt_2010 = 0; d2004 = 32'd0;
    for (int k = 0; k < log_addr.size(); k++) begin
      if (log_addr[k] !== BASE + 32'(4 * k)) errs++;
      if (log_addr[k] === 32'h2010) cnt_2010++;
      if (log_addr[k] === 32'h2004) d2004 = log_data[k];
    end
    chk("rand_order", 32'(errs), 32'd0);
    chk("bp_2010_once", 32'(cnt_2010), 32'd1);
    chk("drain_store", d2004, 32'h12345678);
    chk("wr_err_sticky", 32'(wr_err), 32'd1);
    errs = 0;
    for (int i = 0; i < 256; i++) if (env_mem[i] !== ref_mem[i]) errs++;
    chk("mem_intact", 32'(errs), 32'd0);

    // reset mid-dump at 0x2040, then restart
    @(negedge clk) reset = 0;
    @(negedge clk) reset = 1;
    @(negedge clk) begin trap = 1; dump_ready = 1; end
    @(negedge clk) trap = 0;
    n = 0;
    while (!(dump_valid && dump_addr == 32'h2040) && n < 300) begin @(negedge clk); n++; end
    chk("reach_2040", 32'(n < 300), 32'd1);
    reset = 0; idle_inputs();
    #1;
    chk("mid_rst_valid", 32'(dump_valid), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_stall", 32'(stall_fetch), 32'd0);
    chk("mid_rst_wr_err", 32'(wr_err), 32'd0);
    chk("mid_rst_dump_addr", dump_addr, 32'd0);
    chk("mid_rst_dump_data", dump_data, 32'd0);
    chk("mid_rst_mem_wr", 32'(mem_wr), 32'd0);
    @(negedge clk) reset = 1;
    @(negedge clk) begin trap = 1; dump_ready = 1; end
    @(negedge clk) trap = 0;
    n = 0;
    while (!dump_valid && n < 50) begin @(negedge clk); n++; end
    chk("restart_addr", dump_addr, 32'h2000);
    n = 0;
    while (!done && n < 400) begin @(negedge clk); n++; end
    chk("restart_done", 32'(done), 32'd1);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
